// File: rtl/audio_sample_pacer_pkg.sv
// Shared definitions for the audio sample pacer: sample width, tick counter
// width and the request/convert state encoding.
package audio_sample_pacer_pkg;

  localparam int ADC_DATA_W = 16;
  localparam int TICK_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CONV = 2'd2
  } pacer_state_e;

endpackage

// File: rtl/audio_sample_pacer_fifo.sv
// First-word-fall-through synchronous FIFO: o_data shows the head entry
// whenever o_empty is low. Reusable by other stream stages.
module sync_fifo_fwft #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;
  logic              w_push_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop     = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces ADC conversion requests at a fixed sample rate, captures each sample
// into a FWFT FIFO and streams it out; flags drops and missed ticks.
module audio_sample_pacer
  import audio_sample_pacer_pkg::*;
#(
  parameter int CLK_DIV = 1250,
  parameter int FIFO_AW = 4,
  parameter int DATA_W  = ADC_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               adc_start_conv,
  input  logic               adc_ready,
  input  logic               adc_dat_valid,
  input  logic [DATA_W-1:0]  adc_data,
  output logic [DATA_W-1:0]  s_data,
  output logic               s_valid,
  input  logic               s_ready,
  output logic [FIFO_AW:0]   fill_level,
  output logic               overflow,
  output logic               tick_miss,
  input  logic               clear_flags,
  output pacer_state_e       dbg_state
);

  // Stream handshake: a beat transfers on a clock edge where s_valid and
  // s_ready are both 1; s_data is stable while s_valid=1 and not accepted.

  localparam logic [TICK_CNT_W-1:0] DIV_LAST = TICK_CNT_W'(CLK_DIV - 1);

  logic [TICK_CNT_W-1:0] r_tick_cnt;
  pacer_state_e          r_state;
  pacer_state_e          w_state_nxt;
  logic                  r_dv_prev;
  logic                  r_overflow;
  logic                  r_tick_miss;
  logic                  w_tick;
  logic                  w_dv_rise;
  logic                  w_start_conv;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_tick_miss_evt;
  logic                  w_drop_evt;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  assign w_tick    = enable & (r_tick_cnt == DIV_LAST);
  assign w_dv_rise = adc_dat_valid & ~r_dv_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_dv_prev  <= 1'b0;
    end else begin
      r_dv_prev <= adc_dat_valid;
      if (!enable || r_tick_cnt == DIV_LAST) r_tick_cnt <= '0;
      else                                  r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // adc_ready is only refreshed every few clocks, so REQ holds until it drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_tick)     w_state_nxt = ST_REQ;
      ST_REQ:  if (!adc_ready) w_state_nxt = ST_CONV;
      ST_CONV: if (w_dv_rise)  w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start_conv    = (r_state == ST_REQ);
    w_push          = (r_state == ST_CONV) & w_dv_rise;
    w_tick_miss_evt = w_tick & (r_state != ST_IDLE);
  end

  assign w_pop      = s_valid & s_ready;
  assign w_drop_evt = w_push & w_fifo_full & ~w_pop;

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (adc_data),
    .i_pop   (w_pop),
    .o_data  (s_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fill_level)
  );

  // A new flag event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_tick_miss <= 1'b0;
    end else begin
      if (w_drop_evt)       r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
      if (w_tick_miss_evt)  r_tick_miss <= 1'b1;
      else if (clear_flags) r_tick_miss <= 1'b0;
    end
  end

  assign adc_start_conv = w_start_conv;
  assign s_valid        = ~w_fifo_empty;
  assign overflow       = r_overflow;
  assign tick_miss      = r_tick_miss;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: behavioural ADC reader, reference FIFO
// scoreboard on the output stream, and directed pacing scenarios.
module tb_audio_sample_pacer;
  import audio_sample_pacer_pkg::*;

  localparam int CLK_DIV = 64;
  localparam int AW      = 4;
  localparam int W       = 16;
  localparam int DEPTH   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          adc_start_conv;
  logic          adc_ready;
  logic          adc_dat_valid;
  logic [W-1:0]  adc_data;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW:0]   fill_level;
  logic          overflow;
  logic          tick_miss;
  logic          clear_flags;
  pacer_state_e  dbg_state;

  audio_sample_pacer #(
    .CLK_DIV (CLK_DIV),
    .FIFO_AW (AW),
    .DATA_W  (W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .adc_start_conv (adc_start_conv),
    .adc_ready      (adc_ready),
    .adc_dat_valid  (adc_dat_valid),
    .adc_data       (adc_data),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .tick_miss      (tick_miss),
    .clear_flags    (clear_flags),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural ADC reader ----------------
  int           m_conv_len  = 10;
  logic [W-1:0] m_next_data = '0;
  int           m_samples   = 0;
  int           m_reqs      = 0;

  initial begin
    adc_ready     = 1'b1;
    adc_dat_valid = 1'b0;
    adc_data      = '0;
    forever begin
      @(negedge clk);
      if (adc_start_conv && adc_ready && !reset) begin
        m_reqs++;
        repeat (2) @(posedge clk);
        #1;
        adc_ready     = 1'b0;
        adc_dat_valid = 1'b0;
        repeat (m_conv_len) @(posedge clk);
        #1;
        adc_data      = m_next_data;
        m_next_data   = m_next_data + 1'b1;
        adc_dat_valid = 1'b1;
        adc_ready     = 1'b1;
        m_samples++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_ovf      = 1'b0;
  int           seen_samples = 0;
  int           n_pops       = 0;
  int           n_start_rises = 0;
  logic         prev_start   = 1'b0;
  logic [W-1:0] last_pop     = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_ovf      = 1'b0;
      seen_samples = m_samples;
      prev_start   = 1'b0;
    end else begin
      check_val("sb_fill", 32'(fill_level), 32'(exp_q.size()));
      check_val("sb_valid", 32'(s_valid), 32'(exp_q.size() != 0));
      check_val("sb_overflow", 32'(overflow), 32'(exp_ovf));
      if (exp_q.size() != 0) check_val("sb_head", 32'(s_data), 32'(exp_q[0]));
      if (s_ready && exp_q.size() != 0) begin
        last_pop = exp_q.pop_front();
        n_pops++;
      end
      if (m_samples != seen_samples) begin
        seen_samples = m_samples;
        if (exp_q.size() < DEPTH) exp_q.push_back(adc_data);
        else                      exp_ovf = 1'b1;
      end else if (clear_flags) begin
        exp_ovf = 1'b0;
      end
      if (adc_start_conv && !prev_start) n_start_rises++;
      prev_start = adc_start_conv;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    enable      = 1'b0;
    s_ready     = 1'b0;
    clear_flags = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_start_conv", 32'(adc_start_conv), 32'd0);
    check_val("rst_s_valid", 32'(s_valid), 32'd0);
    check_val("rst_s_data", 32'(s_data), 32'd0);
    check_val("rst_fill", 32'(fill_level), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_tick_miss", 32'(tick_miss), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Returns at posedge+2 right after the model delivers sample number target.
  task automatic wait_samples(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (m_samples < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_val(tag, 32'(m_samples >= target), 32'd1);
  endtask

  task automatic fill_to_full(input string tag);
    int base;
    m_conv_len  = 10;
    m_next_data = '0;
    base        = m_samples;
    enable      = 1'b1;
    wait_samples(base + DEPTH, 3000, tag);
    m_next_data = 16'hBEEF;
  endtask

  task automatic drain(input int cycles);
    s_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    s_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int base;
    int r0;
    int q0;
    int p0;
    reset       = 1'b1;
    enable      = 1'b0;
    s_ready     = 1'b0;
    clear_flags = 1'b0;

    // 1: first request latency and push-to-valid latency
    do_reset();
    m_conv_len  = 10;
    m_next_data = 16'h1234;
    @(posedge clk);
    #1;
    enable = 1'b1;
    cyc    = 0;
    while (!adc_start_conv && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("t1_start_cycle", 32'(cyc), 32'd64);
    wait_samples(1, 200, "t1_sample");
    enable = 1'b0;
    check_val("t1_pre_valid", 32'(s_valid), 32'd0);
    @(posedge clk);
    #2;
    check_val("t1_valid", 32'(s_valid), 32'd1);
    check_val("t1_data", 32'(s_data), 32'h1234);
    drain(3);
    check_val("t1_empty", 32'(fill_level), 32'd0);

    // 2: overflow with consumer stalled, then in-order drain
    do_reset();
    m_conv_len  = 10;
    m_next_data = '0;
    base        = m_samples;
    enable      = 1'b1;
    wait_samples(base + 20, 3000, "t2_samples");
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_val("t2_fill", 32'(fill_level), 32'd16);
    check_val("t2_overflow", 32'(overflow), 32'd1);
    check_val("t2_head", 32'(s_data), 32'd0);
    check_val("t2_no_miss", 32'(tick_miss), 32'd0);
    p0 = n_pops;
    drain(20);
    check_val("t2_pops", 32'(n_pops - p0), 32'd16);
    check_val("t2_last", 32'(last_pop), 32'd15);
    check_val("t2_valid_low", 32'(s_valid), 32'd0);

    // 3: conversion longer than the sample period
    m_conv_len = 120;
    base       = m_samples;
    r0         = n_start_rises;
    q0         = m_reqs;
    enable     = 1'b1;
    wait_samples(base + 4, 3000, "t3_samples");
    enable = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    check_val("t3_tick_miss", 32'(tick_miss), 32'd1);
    check_val("t3_requests", 32'(n_start_rises - r0), 32'd4);
    check_val("t3_model_reqs", 32'(m_reqs - q0), 32'd4);
    check_val("t3_delivered", 32'(m_samples - base), 32'd4);
    check_val("t3_fill", 32'(fill_level), 32'd4);
    drain(8);

    // 6a: clear both sticky flags
    check_val("t6_pre_ovf", 32'(overflow), 32'd1);
    check_val("t6_pre_miss", 32'(tick_miss), 32'd1);
    @(posedge clk);
    #1;
    clear_flags = 1'b1;
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
    #1;
    check_val("t6_clr_ovf", 32'(overflow), 32'd0);
    check_val("t6_clr_miss", 32'(tick_miss), 32'd0);

    // 4: full FIFO, pop and push on the same cycle
    do_reset();
    fill_to_full("t4_fill");
    p0 = n_pops;
    wait_samples(m_samples + 1, 300, "t4_beef");
    s_ready = 1'b1;
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    enable  = 1'b0;
    #1;
    check_val("t4_fill_kept", 32'(fill_level), 32'd16);
    check_val("t4_no_ovf", 32'(overflow), 32'd0);
    drain(20);
    check_val("t4_pops", 32'(n_pops - p0), 32'd17);
    check_val("t4_last_beef", 32'(last_pop), 32'hBEEF);

    // 6b: clear coincident with an overflow event
    do_reset();
    fill_to_full("t6b_fill");
    wait_samples(m_samples + 1, 300, "t6b_drop");
    clear_flags = 1'b1;
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
    enable      = 1'b0;
    #1;
    check_val("t6b_ovf_wins", 32'(overflow), 32'd1);
    check_val("t6b_fill", 32'(fill_level), 32'd16);

    // 5a: enable dropped mid-conversion
    do_reset();
    m_conv_len  = 10;
    m_next_data = 16'hA5A5;
    base        = m_samples;
    enable      = 1'b1;
    cyc         = 0;
    while (adc_ready && cyc < 300) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check_val("t5_conv_seen", 32'(adc_ready), 32'd0);
    enable = 1'b0;
    r0     = n_start_rises;
    wait_samples(base + 1, 200, "t5_sample");
    repeat (300) @(posedge clk);
    #2;
    check_val("t5_no_req", 32'(n_start_rises - r0), 32'd0);
    check_val("t5_one_sample", 32'(m_samples - base), 32'd1);
    check_val("t5_fill", 32'(fill_level), 32'd1);
    check_val("t5_data", 32'(s_data), 32'hA5A5);

    // 5b: reset asserted while requesting
    base   = m_samples;
    enable = 1'b1;
    cyc    = 0;
    while (!adc_start_conv && cyc < 300) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check_val("t5b_req_seen", 32'(adc_start_conv), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_val("t5b_start_low", 32'(adc_start_conv), 32'd0);
    check_val("t5b_fill", 32'(fill_level), 32'd0);
    check_val("t5b_valid", 32'(s_valid), 32'd0);
    check_val("t5b_ovf", 32'(overflow), 32'd0);
    check_val("t5b_miss", 32'(tick_miss), 32'd0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check_val("t5b_no_sample", 32'(m_samples - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
